// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Staged reset release for the CPC2 core. After a fixed hold period and a
// filtered PLL lock, the NUM_STAGES domain resets are released one at a time.
// Each release waits STAGE_DELAY counted clocks, and a stage's count only
// advances while the previous stage reports ready. PLL lock loss sends the
// block back to LOCK_WAIT. A soft reset pulse restarts the whole sequence
// from HOLD.
//
// Ports
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-high reset
//   pll_locked_i     asynchronous PLL lock, synchronised with two flops
//   soft_reset_i     synchronous restart request
//   stage_ready_i    per-stage init-complete flags, synchronous to clock_i
//   n_stage_reset_o  per-stage active-low resets (registered)
//   all_released_o   every stage released and the last stage ready
//   state_o          debug: 0=HOLD 1=LOCK_WAIT 2=RELEASE 3=RUN
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int STAGE_DELAY     = 16,
  parameter int LOCK_FILTER     = 8,
  parameter int SOFT_RESET_HOLD = 64
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  pll_locked_i,
  input  logic                  soft_reset_i,
  input  logic [NUM_STAGES-1:0] stage_ready_i,
  output logic [NUM_STAGES-1:0] n_stage_reset_o,
  output logic                  all_released_o,
  output logic [1:0]            state_o
);

  localparam int HOLD_W  = (SOFT_RESET_HOLD > 1) ? $clog2(SOFT_RESET_HOLD) : 1;
  localparam int FILT_W  = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int DELAY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  // The index can reach NUM_STAGES, meaning "all stages issued, waiting on the
  // last ready". That is why it is one value wider than a plain stage index.
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_LOCK_WAIT = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e                  state_q;
  logic [HOLD_W-1:0]       hold_cnt_q;
  logic [FILT_W-1:0]       filter_cnt_q;
  logic [DELAY_W-1:0]      delay_cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_STAGES-1:0]   n_reset_q;
  logic                    all_released_q;
  logic                    lock_meta_q;
  logic                    lock_s_q;

  logic [NUM_STAGES-1:0]   stage_sel;
  logic [NUM_STAGES-1:0]   prev_sel;
  logic                    count_en;
  logic                    all_issued;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the two stages.
      lock_meta_q <= pll_locked_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Stage selection is done with shifted masks rather than variable bit
  // selects, because idx_q may legitimately point one past the last stage.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    stage_sel  = '0;
    prev_sel   = '0;
    count_en   = 1'b0;
    all_issued = (idx_q == IDX_W'(NUM_STAGES));
    stage_sel  = NUM_STAGES'(1) << idx_q;
    if (idx_q == '0) begin
      count_en = 1'b1;
    end else begin
      prev_sel = NUM_STAGES'(1) << (idx_q - IDX_W'(1));
      count_en = |(stage_ready_i & prev_sel);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      filter_cnt_q   <= '0;
      delay_cnt_q    <= '0;
      idx_q          <= '0;
      n_reset_q      <= '0;
      all_released_q <= 1'b0;
    end else if (soft_reset_i) begin
      // Soft reset wins over everything, including lock loss.
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      filter_cnt_q   <= '0;
      delay_cnt_q    <= '0;
      idx_q          <= '0;
      n_reset_q      <= '0;
      all_released_q <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(SOFT_RESET_HOLD - 1)) begin
            state_q      <= ST_LOCK_WAIT;
            hold_cnt_q   <= '0;
            filter_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end

        ST_LOCK_WAIT: begin
          if (!lock_s_q) begin
            filter_cnt_q <= '0;
          end else if (filter_cnt_q == FILT_W'(LOCK_FILTER - 1)) begin
            state_q      <= ST_RELEASE;
            filter_cnt_q <= '0;
            idx_q        <= '0;
            delay_cnt_q  <= '0;
          end else begin
            filter_cnt_q <= filter_cnt_q + FILT_W'(1);
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (!lock_s_q) begin
            // Lock loss skips HOLD; the clocks are usable again once relocked.
            state_q        <= ST_LOCK_WAIT;
            n_reset_q      <= '0;
            all_released_q <= 1'b0;
            filter_cnt_q   <= '0;
            idx_q          <= '0;
            delay_cnt_q    <= '0;
          end else if (state_q == ST_RELEASE) begin
            if (all_issued) begin
              if (stage_ready_i[NUM_STAGES-1]) begin
                state_q        <= ST_RUN;
                all_released_q <= 1'b1;
              end
            end else if (count_en) begin
              if (delay_cnt_q == DELAY_W'(STAGE_DELAY - 1)) begin
                n_reset_q   <= n_reset_q | stage_sel;
                delay_cnt_q <= '0;
                idx_q       <= idx_q + IDX_W'(1);
              end else begin
                delay_cnt_q <= delay_cnt_q + DELAY_W'(1);
              end
            end
          end
        end

        default: state_q <= ST_HOLD;
      endcase
    end
  end

  assign n_stage_reset_o = n_reset_q;
  assign all_released_o  = all_released_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Bench for reset_sequencer. A behavioural model tracks phase, elapsed clocks
// and the number of released stages. It derives the expected outputs from the
// sequencing rules, and every DUT output is compared against it once per
// clock. Directed scenarios also compare release/fall edge numbers with fixed
// constants.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int SD = 16;
  localparam int LF = 8;
  localparam int SH = 64;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          pll_locked_i;
  logic          soft_reset_i;
  logic [NS-1:0] stage_ready_i;
  logic [NS-1:0] n_stage_reset_o;
  logic          all_released_o;
  logic [1:0]    state_o;

  reset_sequencer #(
    .NUM_STAGES     (NS),
    .STAGE_DELAY    (SD),
    .LOCK_FILTER    (LF),
    .SOFT_RESET_HOLD(SH)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .pll_locked_i   (pll_locked_i),
    .soft_reset_i   (soft_reset_i),
    .stage_ready_i  (stage_ready_i),
    .n_stage_reset_o(n_stage_reset_o),
    .all_released_o (all_released_o),
    .state_o        (state_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Model state: phase 0..3, clocks spent in HOLD, consecutive lock-high
  // clocks, stages released so far and clocks counted toward the next one.
  int m_phase, m_elapsed, m_consec, m_released, m_counted;
  bit m_all;
  bit pll_hist[$];

  int last_rise[NS];
  int last_fall[NS];
  int all_rise;

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_consec = 0; m_released = 0; m_counted = 0;
    m_all = 1'b0;
    pll_hist.delete();
  endtask

  task automatic model_step();
    bit lock_s;
    // The lock seen by the sequencer at this edge is the raw input from two edges ago.
    lock_s = (pll_hist.size() >= 2) ? pll_hist[pll_hist.size()-2] : 1'b0;
    if (soft_reset_i) begin
      m_phase = 0; m_elapsed = 0; m_released = 0; m_counted = 0; m_all = 1'b0;
    end else if (m_phase == 0) begin
      m_elapsed++;
      if (m_elapsed == SH) begin m_phase = 1; m_consec = 0; end
    end else if (m_phase == 1) begin
      if (lock_s) begin
        m_consec++;
        if (m_consec == LF) begin m_phase = 2; m_released = 0; m_counted = 0; end
      end else m_consec = 0;
    end else if (!lock_s) begin
      m_phase = 1; m_consec = 0; m_released = 0; m_counted = 0; m_all = 1'b0;
    end else if (m_phase == 2) begin
      if (m_released == NS) begin
        if (stage_ready_i[NS-1]) begin m_phase = 3; m_all = 1'b1; end
      end else if (m_released == 0 || stage_ready_i[m_released-1]) begin
        m_counted++;
        if (m_counted == SD) begin m_released++; m_counted = 0; end
      end
    end
    pll_hist.push_back(pll_locked_i);
    if (pll_hist.size() > 2) void'(pll_hist.pop_front());
  endtask

  function automatic logic [NS+2:0] exp_vec();
    logic [NS-1:0] mask;
    mask = '0;
    for (int k = 0; k < NS; k++) if (k < m_released) mask[k] = 1'b1;
    return {mask, m_all, 2'(m_phase)};
  endfunction

  // Advance one clock, step the model, and record output edges. Outputs are
  // sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [NS-1:0] prev_n;
    logic          prev_all;
    prev_n   = n_stage_reset_o;
    prev_all = all_released_o;
    @(posedge clock_i);
    if (reset_i) begin model_reset(); edge_no = 0; end
    else begin edge_no++; model_step(); end
    #1;
    for (int k = 0; k < NS; k++) begin
      if (!prev_n[k] && n_stage_reset_o[k]) last_rise[k] = edge_no;
      if (prev_n[k] && !n_stage_reset_o[k]) last_fall[k] = edge_no;
    end
    if (!prev_all && all_released_o) all_rise = edge_no;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; soft_reset_i = 1'b0;
    model_reset();
    for (int k = 0; k < NS; k++) begin last_rise[k] = -1; last_fall[k] = -1; end
    all_rise = -1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; soft_reset_i = 1'b0; pll_locked_i = 1'b1; stage_ready_i = '1;
    #1;
    checks++;
    if ({n_stage_reset_o, all_released_o, state_o} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b want 0", {n_stage_reset_o, all_released_o, state_o});
    end
    do_reset();
    checks++;
    if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_clocked: got %b want %b", {n_stage_reset_o, all_released_o, state_o}, exp_vec());
    end
  endtask

  task automatic test_default_sequence();
    int exp_rise[NS];
    pll_locked_i = 1'b1; stage_ready_i = '1;
    while (edge_no < 140) begin
      tick();
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL default_seq edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    for (int k = 0; k < NS; k++) exp_rise[k] = 88 + 16 * k;
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (last_rise[k] != exp_rise[k]) begin
        errors++;
        $display("FAIL default_rise[%0d]: got %0d want %0d", k, last_rise[k], exp_rise[k]);
      end
    end
    checks++;
    if (all_rise != 137 || state_o !== 2'd3) begin
      errors++;
      $display("FAIL default_run: all_rise %0d state %0d want 137 and 3", all_rise, state_o);
    end
  endtask

  task automatic test_soft_reset();
    int p;
    while (edge_no < 149) begin
      tick();
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL soft_pre edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    soft_reset_i = 1'b1;
    tick();
    soft_reset_i = 1'b0;
    p = edge_no;
    checks++;
    if (n_stage_reset_o !== '0 || all_released_o !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL soft_pulse: got n=%b all=%b state=%0d want 0/0/0",
               n_stage_reset_o, all_released_o, state_o);
    end
    while (edge_no < p + 140) begin
      tick();
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL soft_seq edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (last_rise[k] != p + 88 + 16 * k) begin
        errors++;
        $display("FAIL soft_rise[%0d]: got %0d want %0d", k, last_rise[k], p + 88 + 16 * k);
      end
    end
    checks++;
    if (all_rise != p + 137) begin
      errors++;
      $display("FAIL soft_all: got %0d want %0d", all_rise, p + 137);
    end
  endtask

  task automatic test_ready_stall();
    do_reset();
    pll_locked_i = 1'b1; stage_ready_i = '1;
    while (edge_no < 240) begin
      stage_ready_i[1] = (edge_no + 1 > 200);
      tick();
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL stall edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    checks++;
    if (last_rise[1] != 104 || last_rise[2] != 216 || last_rise[3] != 232 || all_rise != 233) begin
      errors++;
      $display("FAIL stall_rise: got %0d %0d %0d all %0d want 104 216 232 all 233",
               last_rise[1], last_rise[2], last_rise[3], all_rise);
    end
  endtask

  task automatic test_lock_loss();
    do_reset();
    pll_locked_i = 1'b1; stage_ready_i = '1;
    while (edge_no < 150) begin
      pll_locked_i = !((edge_no + 1) >= 110 && (edge_no + 1) <= 112);
      tick();
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL lockloss edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    checks++;
    if (last_fall[0] != 112 || last_fall[1] != 112 || last_rise[0] != 138) begin
      errors++;
      $display("FAIL lockloss_edges: fall %0d/%0d rise %0d want 112/112 138",
               last_fall[0], last_fall[1], last_rise[0]);
    end
  endtask

  task automatic test_lock_toggle();
    int seen_release;
    seen_release = 0;
    do_reset();
    stage_ready_i = '1;
    while (edge_no < 200) begin
      pll_locked_i = (((edge_no + 1) / 3) % 2) == 0;
      tick();
      if (state_o == 2'd2 || n_stage_reset_o != '0) seen_release++;
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL toggle edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    checks++;
    if (seen_release != 0) begin
      errors++;
      $display("FAIL toggle_release: got %0d released clocks want 0", seen_release);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pll_locked_i = 1'b1; stage_ready_i = '1;
    while (edge_no < 110) begin
      tick();
      checks++;
      if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
        errors++;
        $display("FAIL async_pre edge %0d: got %b want %b", edge_no,
                 {n_stage_reset_o, all_released_o, state_o}, exp_vec());
      end
    end
    checks++;
    if (n_stage_reset_o !== 4'b0011 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL async_mid: got n=%b state=%0d want 0011 and 2", n_stage_reset_o, state_o);
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (n_stage_reset_o !== '0 || all_released_o !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got n=%b all=%b state=%0d want 0/0/0",
               n_stage_reset_o, all_released_o, state_o);
    end
    model_reset();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_random();
    int drop_left;
    for (int ep = 0; ep < 3; ep++) begin
      do_reset();
      drop_left = 0;
      pll_locked_i = 1'b1;
      for (int i = 0; i < 800; i++) begin
        if (drop_left > 0) begin pll_locked_i = 1'b0; drop_left--; end
        else begin
          pll_locked_i = 1'b1;
          if ($urandom_range(0, 79) == 0) drop_left = $urandom_range(1, 4);
        end
        soft_reset_i = ($urandom_range(0, 399) == 0);
        for (int k = 0; k < NS; k++) stage_ready_i[k] = ($urandom_range(0, 7) != 0);
        tick();
        checks++;
        if ({n_stage_reset_o, all_released_o, state_o} !== exp_vec()) begin
          errors++;
          $display("FAIL random ep %0d edge %0d: got %b want %b", ep, edge_no,
                   {n_stage_reset_o, all_released_o, state_o}, exp_vec());
        end
      end
      soft_reset_i = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_sequence();
    test_soft_reset();
    test_ready_stall();
    test_lock_loss();
    test_lock_toggle();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
